// File: rtl/rr_arb_mux_pkg.sv
// +--------------------------------------------------------------------+
// | rr_arb_mux_pkg - shared state type and width helper for rr_arb_mux  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rr_arb_mux_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Index width for a channel count; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter - combinational rotating-priority grant from ptr upward  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic [NUM_CH-1:0] at_or_above;
  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] pick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_mask
    assign at_or_above[i] = (SEL_W'(i) >= ptr);
  end

  // Requests at or above ptr win; otherwise the search wraps to channel 0.
  assign upper = req & at_or_above;
  assign pick  = (|upper) ? upper : req;
  assign grant = pick & (~pick + ONE);

  for (genvar b = 0; b < SEL_W; b++) begin : g_enc
    logic [NUM_CH-1:0] bit_mask;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign bit_mask[i] = (((i >> b) & 1) == 1);
    end
    assign grant_idx[b] = |(grant & bit_mask);
  end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// +--------------------------------------------------------------------+
// | rr_arb_mux - round-robin N:1 valid/ready mux, registered output;    |
// | optional grant hold via ARB_MUX_LOCK_EN. Rev 1.0                   |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef ARB_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       in_lock,
`endif
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  sel_q;

  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic [SEL_W-1:0]  ptr_next;
  logic [WIDTH-1:0]  mux_acc [NUM_CH+1];

  assign out_valid = (state == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Reset gates load_en so nothing is offered while rst_n is low.
  assign load_en = rst_n && (!out_valid || out_ready);

`ifdef ARB_MUX_LOCK_EN
  logic              lock_q;
  logic [SEL_W-1:0]  lock_ch;
  logic [NUM_CH-1:0] lock_mask;
  logic              lock_beat;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lock_mask
    assign lock_mask[i] = (lock_ch == SEL_W'(i));
  end

  assign req       = lock_q ? (in_valid & lock_mask) : in_valid;
  assign lock_beat = |(grant & in_lock);
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready = load_en ? grant : '0;
  assign xfer     = |in_ready;

  // One-hot AND-OR select keeps the data path free of a wide index decode.
  assign mux_acc[0] = '0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_mux
    assign mux_acc[i+1] = mux_acc[i] | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end
  assign grant_data = mux_acc[NUM_CH];

  // Wrap at NUM_CH rather than 2^SEL_W.
  assign ptr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= '0;
`ifdef ARB_MUX_LOCK_EN
      lock_q  <= 1'b0;
      lock_ch <= '0;
`endif
    end else if (load_en) begin
      if (xfer) begin
        state  <= ST_FULL;
        data_q <= grant_data;
        sel_q  <= grant_idx;
`ifdef ARB_MUX_LOCK_EN
        if (lock_beat) begin
          lock_q  <= 1'b1;
          lock_ch <= grant_idx;
        end else begin
          lock_q <= 1'b0;
          ptr    <= ptr_next;
        end
`else
        ptr <= ptr_next;
`endif
      end else begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// +--------------------------------------------------------------------+
// | tb_rr_arb_mux - directed bench for rr_arb_mux (4- and 3-channel)    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rr_arb_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   v4, r4, lk4;
  logic [127:0] fd4;
  logic         ov4, or4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic [2:0]   v3, r3;
  logic [95:0]  fd3;
  logic         ov3, or3;
  logic [31:0]  od3;
  logic [1:0]   os3;
  logic [31:0]  d4 [4];
  logic [31:0]  d3 [3];

  int  total = 0;
  int  bad   = 0;
  bit  chk_en = 1'b0;

  int  m_ptr [2];
  bit  m_ov  [2];
  logic [31:0] m_od [2];
  int  m_os  [2];
  bit  m_lq  [2];
  int  m_lc  [2];

  int  exp_seq  [6] = '{0, 1, 2, 3, 0, 1};
  int  exp_wrap [4] = '{2, 0, 2, 0};

  always #5 clk = ~clk;

  assign fd4 = {d4[3], d4[2], d4[1], d4[0]};
  assign fd3 = {d3[2], d3[1], d3[0]};

  rr_arb_mux #(.WIDTH(32), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .in_data   (fd4),
    .in_ready  (r4),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (lk4),
`endif
    .out_valid (ov4),
    .out_data  (od4),
    .out_sel   (os4),
    .out_ready (or4)
  );

  rr_arb_mux #(.WIDTH(32), .NUM_CH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v3),
    .in_data   (fd3),
    .in_ready  (r3),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (3'b000),
`endif
    .out_valid (ov3),
    .out_data  (od3),
    .out_sel   (os3),
    .out_ready (or3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid eligible channel scanning ptr, ptr+1, ... modulo n; -1 if none offered.
  function automatic int pick(input int n, input logic [3:0] v, input int p, input bit lq,
                              input int lc, input bit rn, input bit ov, input bit ordy);
    int c;
    if (!rn || (ov && !ordy)) return -1;
    for (int k = 0; k < n; k++) begin
      c = (p + k) % n;
      if (v[c] && (!lq || c == lc)) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return (g < 0) ? 4'b0000 : (one << g);
  endfunction

  task automatic step(input int k, input int n, input logic [3:0] v, input logic [3:0] lk, input bit ordy);
    int g;
    bit lock_beat;
    if (!rst_n) begin
      m_ptr[k] = 0; m_ov[k] = 0; m_od[k] = '0; m_os[k] = 0; m_lq[k] = 0; m_lc[k] = 0;
      return;
    end
    g = pick(n, v, m_ptr[k], m_lq[k], m_lc[k], 1'b1, m_ov[k], ordy);
    if (m_ov[k] && !ordy) return;
    if (g < 0) begin
      m_ov[k] = 0;
      return;
    end
    m_ov[k] = 1;
    m_od[k] = (k == 0) ? d4[g] : d3[g];
    m_os[k] = g;
    lock_beat = 1'b0;
`ifdef ARB_MUX_LOCK_EN
    lock_beat = lk[g];
`endif
    if (lock_beat) begin
      m_lq[k] = 1; m_lc[k] = g;
    end else begin
      m_lq[k] = 0; m_ptr[k] = (g + 1) % n;
    end
  endtask

  always @(posedge clk) begin
    step(0, 4, v4, lk4, or4);
    step(1, 3, {1'b0, v3}, 4'b0000, or3);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m4_valid", ov4, m_ov[0]);
      check("m4_ready", r4, onehot(pick(4, v4, m_ptr[0], m_lq[0], m_lc[0], rst_n, m_ov[0], or4)));
      if (m_ov[0]) begin
        check("m4_data", od4, m_od[0]);
        check("m4_sel", os4, m_os[0]);
      end
      check("m3_valid", ov3, m_ov[1]);
      check("m3_ready", r3, 3'(onehot(pick(3, {1'b0, v3}, m_ptr[1], m_lq[1], m_lc[1], rst_n, m_ov[1], or3))));
      if (m_ov[1]) begin
        check("m3_data", od3, m_od[1]);
        check("m3_sel", os3, m_os[1]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d4[i] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) d3[i] = 32'hC0 + i;
    rst_n = 1'b0; v4 = 4'hF; lk4 = 4'h0; or4 = 1'b1; v3 = 3'b000; or3 = 1'b1;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk_en = 1'b1;
      check("rst_valid", ov4, 0);
      check("rst_data", od4, 0);
      check("rst_sel", os4, 0);
      check("rst_ready", r4, 0);
    end
    rst_n = 1'b1;
    #1 check("first_grant", r4, 4'b0001);

    for (int j = 0; j < 6; j++) begin
      tick();
      check("rr_sel", os4, exp_seq[j]);
      check("rr_data", od4, 32'hA0 + exp_seq[j]);
      check("rr_valid", ov4, 1);
    end

    or4 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("bp_data", od4, 32'hA1);
      check("bp_ready", r4, 0);
    end
    or4 = 1'b1;
    #1 check("bp_release_ready", r4, 4'b0100);
    tick();
    check("bp_next_sel", os4, 2);
    check("bp_next_data", od4, 32'hA2);

    v4 = 4'b0010;
    tick();
    check("idle_sel", os4, 1);
    check("idle_valid", ov4, 1);
    v4 = 4'b0000;
    tick();
    check("idle_drop", ov4, 0);
    v4 = 4'hF;
    #1 check("idle_ptr", r4, 4'b0100);
    tick();
    check("idle_resume", os4, 2);

    v3 = 3'b001;
    tick();
    check("wrap_prime", os3, 0);
    v3 = 3'b101;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("wrap_sel", os3, exp_wrap[j]);
      check("wrap_data", od3, 32'hC0 + exp_wrap[j]);
    end
    v3 = 3'b000;

`ifdef ARB_MUX_LOCK_EN
    v4 = 4'b1000;
    tick();
    check("lock_prime", os4, 3);
    v4 = 4'b0011; lk4 = 4'b0001;
    #1 check("lock_first_ready", r4, 4'b0001);
    for (int j = 0; j < 3; j++) begin
      tick();
      check("lock_sel", os4, 0);
      check("lock_hold_ready", r4, 4'b0001);
    end
    lk4 = 4'b0000;
    tick();
    check("unlock_sel", os4, 0);
    check("unlock_ready", r4, 4'b0010);
    tick();
    check("after_unlock_sel", os4, 1);
`endif

    v4 = 4'b0000;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
